// File: rtl/airlock_sequencer_pkg.sv
// Shared definitions for the airlock sequencer: state encoding, sequence
// direction and default timing constants.
package airlock_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_EVAC    = 4'd1,
      ST_OPEN_O  = 4'd2,
      ST_DWELL_O = 4'd3,
      ST_CLOSE_O = 4'd4,
      ST_PRESS   = 4'd5,
      ST_OPEN_I  = 4'd6,
      ST_DWELL_I = 4'd7,
      ST_CLOSE_I = 4'd8,
      ST_FAULT   = 4'd9
   } state_t;

   typedef enum logic {
      SEQ_ARRIVE = 1'b0,
      SEQ_DEPART = 1'b1
   } seq_t;

   localparam int unsigned DEF_EVAC_CYCLES  = 8;
   localparam int unsigned DEF_PRESS_CYCLES = 8;
   localparam int unsigned DEF_DWELL_CYCLES = 4;
   localparam int unsigned DEF_ACK_TIMEOUT  = 6;
   localparam int unsigned DEF_CNT_W        = 4;

   // States whose first cycle carries a flip pulse to the outer port
   function automatic logic flips_outer(input state_t s);
      return (s == ST_OPEN_O) || (s == ST_CLOSE_O);
   endfunction

   // States whose first cycle carries a flip pulse to the inner port
   function automatic logic flips_inner(input state_t s);
      return (s == ST_OPEN_I) || (s == ST_CLOSE_I);
   endfunction

endpackage

// File: rtl/airlock_sequencer_phase_timer.sv
// Down-counter used for phase durations and acknowledge timeouts.
// Loads a value on strobe, counts down to zero and holds there.
module phase_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec_en,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   // Load has priority over decrement; the count saturates at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec_en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock sequencer: drives the outer/inner OCPort flip pulses, sequences
// evacuation and pressurization, and enforces the port interlock.
module airlock_sequencer
   import airlock_sequencer_pkg::*;
#(
   parameter int unsigned EVAC_CYCLES  = DEF_EVAC_CYCLES,
   parameter int unsigned PRESS_CYCLES = DEF_PRESS_CYCLES,
   parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
   parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic Clock,
   input  logic Reset,
   input  logic ArriveReq,
   input  logic DepartReq,
   input  logic OuterOpen,
   input  logic InnerOpen,
   output logic OuterFlip,
   output logic InnerFlip,
   output logic Pressurized,
   output logic Busy,
   output logic Done,
   output logic Fault
);

   state_t           state, nxt;
   seq_t             seq, nxt_seq;
   logic             outer_q, inner_q;
   logic             enter;
   logic             violation;
   logic             ph_load, ack_load;
   logic [CNT_W-1:0] ph_val;
   logic [CNT_W-1:0] ph_cnt;
   logic             ph_zero;
   logic [CNT_W-1:0] ack_cnt_unused;
   logic             ack_zero;

   phase_timer #(.CNT_W(CNT_W)) u_phase (
      .clk      (Clock),
      .rst_n    (Reset),
      .load     (ph_load),
      .load_val (ph_val),
      .dec_en   (1'b1),
      .cnt      (ph_cnt),
      .zero     (ph_zero)
   );

   phase_timer #(.CNT_W(CNT_W)) u_ack (
      .clk      (Clock),
      .rst_n    (Reset),
      .load     (ack_load),
      .load_val (CNT_W'(ACK_TIMEOUT - 1)),
      .dec_en   (1'b1),
      .cnt      (ack_cnt_unused),
      .zero     (ack_zero)
   );

   // Next-state decode: nominal path first, then interlock overrides, then timer loads
   always_comb begin
      nxt      = state;
      nxt_seq  = seq;
      ph_load  = 1'b0;
      ph_val   = '0;
      ack_load = 1'b0;

      // A port may only change while its own OPEN/CLOSE wait is active
      violation = (OuterOpen & InnerOpen)
                | ((OuterOpen ^ outer_q) & ~flips_outer(state))
                | ((InnerOpen ^ inner_q) & ~flips_inner(state));

      unique case (state)
         ST_IDLE: begin
            if (ArriveReq) begin
               nxt     = ST_EVAC;
               nxt_seq = SEQ_ARRIVE;
            end else if (DepartReq) begin
               nxt     = ST_OPEN_I;
               nxt_seq = SEQ_DEPART;
            end
         end
         ST_EVAC:    if (ph_zero) nxt = ST_OPEN_O;
         ST_OPEN_O: begin
            if (OuterOpen)     nxt = ST_DWELL_O;
            else if (ack_zero) nxt = ST_FAULT;
         end
         ST_DWELL_O: if (ph_zero) nxt = ST_CLOSE_O;
         ST_CLOSE_O: begin
            if (!OuterOpen)    nxt = ST_PRESS;
            else if (ack_zero) nxt = ST_FAULT;
         end
         ST_PRESS:   if (ph_zero) nxt = (seq == SEQ_ARRIVE) ? ST_OPEN_I : ST_IDLE;
         ST_OPEN_I: begin
            if (InnerOpen)     nxt = ST_DWELL_I;
            else if (ack_zero) nxt = ST_FAULT;
         end
         ST_DWELL_I: if (ph_zero) nxt = ST_CLOSE_I;
         ST_CLOSE_I: begin
            if (!InnerOpen)    nxt = (seq == SEQ_ARRIVE) ? ST_IDLE : ST_EVAC;
            else if (ack_zero) nxt = ST_FAULT;
         end
         ST_FAULT:   nxt = ST_FAULT;
         default:    nxt = ST_FAULT;
      endcase

      // Refuse to flip a port while the opposite one reads open
      if ((nxt != state) && flips_outer(nxt) && InnerOpen) nxt = ST_FAULT;
      if ((nxt != state) && flips_inner(nxt) && OuterOpen) nxt = ST_FAULT;
      if ((state != ST_FAULT) && violation) nxt = ST_FAULT;

      enter = (nxt != state);

      if (enter) begin
         unique case (nxt)
            ST_EVAC:    begin ph_load = 1'b1; ph_val = CNT_W'(EVAC_CYCLES - 1);  end
            ST_PRESS:   begin ph_load = 1'b1; ph_val = CNT_W'(PRESS_CYCLES - 1); end
            ST_DWELL_O,
            ST_DWELL_I: begin ph_load = 1'b1; ph_val = CNT_W'(DWELL_CYCLES - 1); end
            default:    ph_load = 1'b0;
         endcase
         ack_load = flips_outer(nxt) | flips_inner(nxt);
      end
   end

   // State register and registered output decode
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state       <= ST_IDLE;
         seq         <= SEQ_ARRIVE;
         outer_q     <= 1'b0;
         inner_q     <= 1'b0;
         OuterFlip   <= 1'b0;
         InnerFlip   <= 1'b0;
         Pressurized <= 1'b1;
         Busy        <= 1'b0;
         Done        <= 1'b0;
         Fault       <= 1'b0;
      end else begin
         state     <= nxt;
         seq       <= nxt_seq;
         outer_q   <= OuterOpen;
         inner_q   <= InnerOpen;
         OuterFlip <= enter && flips_outer(nxt);
         InnerFlip <= enter && flips_inner(nxt);
         Busy      <= (nxt != ST_IDLE) && (nxt != ST_FAULT);
         Done      <= (nxt == ST_IDLE) && (state != ST_IDLE);
         Fault     <= Fault | (nxt == ST_FAULT);
         // Set one edge early so the flag is already high during the final PRESS cycle
         if (enter && (nxt == ST_EVAC)) begin
            Pressurized <= 1'b0;
         end else if ((state == ST_PRESS) && (nxt == ST_PRESS) && (ph_cnt == CNT_W'(1))) begin
            Pressurized <= 1'b1;
         end else if (enter && (nxt == ST_PRESS) && (PRESS_CYCLES == 1)) begin
            Pressurized <= 1'b1;
         end
      end
   end

endmodule
